pipe_ctrl: RTL and testbench

Pipeline control unit for the 3-stage fetch/decode/execution CPU.
- Detects RAW hazards between the decode-stage source registers and the execution/writeback destinations (rdest_r/we, rdest_rr/we_r).
- Produces operand-forwarding selects, plus stall and bubble for load-class ops.
- Provides a debug run/halt/single-step FSM with request/ack handshake, and issue and stall performance counters.

---
 rtl/pipe_ctrl.sv | 135 +++++++++++++
 tb/tb_pipe_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline control for the 3-stage fetch/decode/execute CPU: RAW forwarding
// selects, load-use stall/bubble, debug run/halt/step FSM and perf counters.

module pipe_ctrl_src #(
    parameter int REG_AW      = 4,
    parameter bit ZERO_REG_EN = 1'b0
) (
    input  logic [REG_AW-1:0] rs,
    input  logic              rs_use,
    input  logic [REG_AW-1:0] rdest_r,
    input  logic              we,
    input  logic              ld_r,
    input  logic [REG_AW-1:0] rdest_rr,
    input  logic              we_r,
    output logic [1:0]        fwd,
    output logic              ld_haz
);
    logic zero_mask, m_ex, m_wb;

    assign zero_mask = ZERO_REG_EN && (rs == '0);
    assign m_ex      = rs_use && (rs == rdest_r)  && !zero_mask;
    assign m_wb      = rs_use && (rs == rdest_rr) && !zero_mask;

    // A load in execution has no result yet; it forwards from writeback next cycle.
    always_comb begin
        fwd = 2'b00;
        if (m_ex && we && !ld_r)
            fwd = 2'b01;
        else if (m_wb && we_r)
            fwd = 2'b10;
    end

    assign ld_haz = m_ex && we && ld_r;
endmodule

module pipe_ctrl #(
    parameter int REG_AW      = 4,
    parameter int CNT_W       = 16,
    parameter bit ZERO_REG_EN = 1'b0,
    parameter bit BOOT_HALT   = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs_a,
    input  logic [REG_AW-1:0] rs_b,
    input  logic              rs_a_use,
    input  logic              rs_b_use,
    input  logic [REG_AW-1:0] rdest_r,
    input  logic              we,
    input  logic              ld_r,
    input  logic [REG_AW-1:0] rdest_rr,
    input  logic              we_r,
    input  logic              halt_req,
    input  logic              run_req,
    input  logic              step_req,
    input  logic              cnt_clr,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              stall,
    output logic              bubble,
    output logic              pipe_en,
    output logic              halted,
    output logic              step_ack,
    output logic [CNT_W-1:0]  issue_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);
    localparam int NUM_SRC = 2;

    typedef enum logic [1:0] {RUN, HALT, STEP} state_t;
    state_t state, state_nxt;

    logic [NUM_SRC-1:0][REG_AW-1:0] rs_v;
    logic [NUM_SRC-1:0]             use_v, haz_v;
    logic [NUM_SRC-1:0][1:0]        fwd_v;
    logic                           haz;

    assign rs_v  = {rs_b, rs_a};
    assign use_v = {rs_b_use, rs_a_use};

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        pipe_ctrl_src #(.REG_AW(REG_AW), .ZERO_REG_EN(ZERO_REG_EN)) u_src (
            .rs      (rs_v[i]),
            .rs_use  (use_v[i]),
            .rdest_r (rdest_r),
            .we      (we),
            .ld_r    (ld_r),
            .rdest_rr(rdest_rr),
            .we_r    (we_r),
            .fwd     (fwd_v[i]),
            .ld_haz  (haz_v[i])
        );
    end

    assign haz   = |haz_v;
    assign fwd_a = rst ? 2'b00 : fwd_v[0];
    assign fwd_b = rst ? 2'b00 : fwd_v[1];

    always_ff @(posedge clk) begin
        if (rst)
            state <= BOOT_HALT ? HALT : RUN;
        else
            state <= state_nxt;
    end

    // Halt request dominates run/step while halted.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (halt_req) state_nxt = HALT;
            HALT: begin
                if (halt_req)      state_nxt = HALT;
                else if (run_req)  state_nxt = RUN;
                else if (step_req) state_nxt = STEP;
            end
            STEP:    state_nxt = HALT;
            default: state_nxt = HALT;
        endcase
    end

    assign pipe_en  = !rst && (state == RUN || state == STEP);
    assign stall    = haz && pipe_en;
    assign bubble   = stall;
    assign halted   = (state == HALT);
    assign step_ack = !rst && (state == STEP);

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            issue_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (pipe_en && !bubble) issue_cnt <= issue_cnt + CNT_W'(1);
            if (stall)              stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: u0 default-style config (4-bit counters for
// wrap), u1 with zero-register masking and boot-to-halt.

module tb_pipe_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] rs_a, rs_b, rdest_r, rdest_rr;
    logic       rs_a_use, rs_b_use, we, ld_r, we_r;
    logic       halt_req, run_req, step_req, cnt_clr;

    logic [1:0]  fwd_a0, fwd_b0, fwd_a1, fwd_b1;
    logic        stall0, bubble0, pipe_en0, halted0, step_ack0;
    logic        stall1, bubble1, pipe_en1, halted1, step_ack1;
    logic [3:0]  issue_cnt0, stall_cnt0;
    logic [15:0] issue_cnt1, stall_cnt1;

    int nv = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.REG_AW(4), .CNT_W(4), .ZERO_REG_EN(1'b0), .BOOT_HALT(1'b0)) u0 (
        .clk(clk), .rst(rst), .rs_a(rs_a), .rs_b(rs_b), .rs_a_use(rs_a_use),
        .rs_b_use(rs_b_use), .rdest_r(rdest_r), .we(we), .ld_r(ld_r),
        .rdest_rr(rdest_rr), .we_r(we_r), .halt_req(halt_req), .run_req(run_req),
        .step_req(step_req), .cnt_clr(cnt_clr), .fwd_a(fwd_a0), .fwd_b(fwd_b0),
        .stall(stall0), .bubble(bubble0), .pipe_en(pipe_en0), .halted(halted0),
        .step_ack(step_ack0), .issue_cnt(issue_cnt0), .stall_cnt(stall_cnt0)
    );

    pipe_ctrl #(.REG_AW(4), .CNT_W(16), .ZERO_REG_EN(1'b1), .BOOT_HALT(1'b1)) u1 (
        .clk(clk), .rst(rst), .rs_a(rs_a), .rs_b(rs_b), .rs_a_use(rs_a_use),
        .rs_b_use(rs_b_use), .rdest_r(rdest_r), .we(we), .ld_r(ld_r),
        .rdest_rr(rdest_rr), .we_r(we_r), .halt_req(halt_req), .run_req(run_req),
        .step_req(step_req), .cnt_clr(cnt_clr), .fwd_a(fwd_a1), .fwd_b(fwd_b1),
        .stall(stall1), .bubble(bubble1), .pipe_en(pipe_en1), .halted(halted1),
        .step_ack(step_ack1), .issue_cnt(issue_cnt1), .stall_cnt(stall_cnt1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nv++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rs_a = 0; rs_b = 0; rs_a_use = 0; rs_b_use = 0;
        rdest_r = 0; we = 0; ld_r = 0; rdest_rr = 0; we_r = 0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        halt_req = 0; run_req = 0; step_req = 0; cnt_clr = 0;

        // reset: hazard inputs present but all control outputs quiet
        tick();
        we = 1; ld_r = 1; rdest_r = 2; rs_a = 2; rs_a_use = 1;
        #1;
        chk("rst_stall", stall0, 0);
        chk("rst_bubble", bubble0, 0);
        chk("rst_pipe_en", pipe_en0, 0);
        chk("rst_fwd_a", fwd_a0, 2'b00);
        tick();
        chk("rst_issue", issue_cnt0, 0);
        chk("rst_stallcnt", stall_cnt0, 0);
        chk("rst_halted0", halted0, 0);
        chk("rst_halted1", halted1, 1);
        chk("rst_step_ack", step_ack0, 0);
        idle_inputs();
        rst = 1'b0;
        #1;
        chk("run_pipe_en0", pipe_en0, 1);
        chk("boot_halt_pipe_en1", pipe_en1, 0);

        // bring u1 out of boot halt; u0 ignores run_req in RUN
        run_req = 1;
        tick();
        run_req = 0;
        #1;
        chk("u1_run", pipe_en1, 1);
        chk("first_issue", issue_cnt0, 1);

        // 1: back-to-back ALU RAW
        cnt_clr = 1;
        rdest_r = 3; we = 1; rs_a = 3; rs_a_use = 1;
        #1;
        chk("alu_fwd_ex", fwd_a0, 2'b01);
        chk("alu_nostall", stall0, 0);
        tick();
        cnt_clr = 0;
        rdest_rr = 3; we_r = 1; rdest_r = 5;
        #1;
        chk("alu_fwd_wb", fwd_a0, 2'b10);
        chk("clr_issue", issue_cnt0, 0);
        tick();
        chk("issue_inc", issue_cnt0, 1);

        // 2: both stages write r4
        idle_inputs();
        rdest_r = 4; we = 1; rdest_rr = 4; we_r = 1; rs_b = 4; rs_b_use = 1;
        #1;
        chk("prio_ex", fwd_b0, 2'b01);
        we = 0;
        #1;
        chk("prio_wb", fwd_b0, 2'b10);
        rs_b_use = 0;
        #1;
        chk("no_use", fwd_b0, 2'b00);

        // 3: load-use
        idle_inputs();
        cnt_clr = 1;
        tick();
        cnt_clr = 0;
        ld_r = 1; we = 1; rdest_r = 2; rs_b = 2; rs_b_use = 1;
        #1;
        chk("ld_b_stall", stall0, 1);
        chk("ld_b_fwd", fwd_b0, 2'b00);
        rs_b_use = 0; rs_a = 2; rs_a_use = 1;
        #1;
        chk("ld_stall", stall0, 1);
        chk("ld_bubble", bubble0, 1);
        chk("ld_fwd_a", fwd_a0, 2'b00);
        tick();
        chk("ld_stallcnt", stall_cnt0, 1);
        chk("ld_noissue", issue_cnt0, 0);
        ld_r = 0; we = 0; rdest_r = 0; rdest_rr = 2; we_r = 1;
        #1;
        chk("ld_release", stall0, 0);
        chk("ld_fwd_wb", fwd_a0, 2'b10);
        tick();
        chk("ld_issue", issue_cnt0, 1);
        chk("ld_stallcnt_hold", stall_cnt0, 1);

        // 4: zero register masking
        idle_inputs();
        rs_a = 0; rs_a_use = 1; rdest_r = 0; we = 1; ld_r = 1;
        #1;
        chk("zr_fwd", fwd_a1, 2'b00);
        chk("zr_stall", stall1, 0);
        chk("nozr_stall", stall0, 1);
        ld_r = 0;
        #1;
        chk("zr_alu_fwd", fwd_a1, 2'b00);
        chk("nozr_alu_fwd", fwd_a0, 2'b01);
        idle_inputs();

        // 5: debug halt / step / run
        cnt_clr = 1;
        tick();
        cnt_clr = 0;
        halt_req = 1;
        #1;
        chk("halt_cycle_adv", pipe_en0, 1);
        tick();
        halt_req = 0;
        #1;
        chk("halted", halted0, 1);
        chk("halt_pipe_en", pipe_en0, 0);
        chk("halt_issue", issue_cnt0, 1);
        tick();
        chk("halt_hold_issue", issue_cnt0, 1);
        step_req = 1;
        tick();
        step_req = 0;
        #1;
        chk("step1_ack", step_ack0, 1);
        chk("step1_pipe_en", pipe_en0, 1);
        chk("step1_halted", halted0, 0);
        tick();
        chk("step1_ack_off", step_ack0, 0);
        chk("step1_rehalt", halted0, 1);
        chk("step1_issue", issue_cnt0, 2);
        step_req = 1;
        tick();
        step_req = 0;
        #1;
        chk("step2_ack", step_ack0, 1);
        tick();
        chk("step2_rehalt", halted0, 1);
        chk("step2_issue", issue_cnt0, 3);
        halt_req = 1; run_req = 1;
        tick();
        chk("halt_wins", halted0, 1);
        halt_req = 0;
        tick();
        run_req = 0;
        #1;
        chk("resume_halted", halted0, 0);
        chk("resume_pipe_en", pipe_en0, 1);

        // 6: counter wrap, clear priority, reset during step
        cnt_clr = 1;
        tick();
        cnt_clr = 0;
        repeat (15) tick();
        chk("cnt_max", issue_cnt0, 15);
        tick();
        chk("cnt_wrap", issue_cnt0, 0);
        tick();
        chk("cnt_after_wrap", issue_cnt0, 1);
        cnt_clr = 1;
        tick();
        cnt_clr = 0;
        chk("clr_beats_issue", issue_cnt0, 0);
        ld_r = 1; we = 1; rdest_r = 7; rs_a = 7; rs_a_use = 1;
        tick();
        chk("stallcnt_one", stall_cnt0, 1);
        cnt_clr = 1;
        tick();
        cnt_clr = 0;
        chk("clr_beats_stall", stall_cnt0, 0);
        idle_inputs();
        halt_req = 1;
        tick();
        halt_req = 0;
        step_req = 1;
        tick();
        step_req = 0;
        #1;
        chk("pre_rst_step", step_ack0, 1);
        rst = 1;
        #1;
        chk("rst_step_abort", step_ack0, 0);
        chk("rst_step_pipe_en", pipe_en0, 0);
        tick();
        chk("rst_state0", halted0, 0);
        chk("rst_state1", halted1, 1);
        chk("rst_ack_after", step_ack0, 0);
        chk("rst_cnt", issue_cnt0, 0);
        rst = 0;
        #1;
        chk("post_rst_pipe_en", pipe_en0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nv, nerr);
        $finish;
    end
endmodule
